// File: rtl/user_strm_src_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_strm_src_arbiter_pkg
// Description : Shared types and constants for the user source-stream
//               arbiter: default stream count and widths, arbiter state
//               encoding and the statistics counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package user_strm_src_arbiter_pkg;

    localparam int N_STRM_AXI    = 4;
    localparam int AXI_DATA_BITS = 512;
    localparam int PID_BITS      = 6;
    localparam int ARB_CNT_BITS  = 32;

    // IDLE: no input holds the grant. LOCK: the recorded input owns the
    // output until its tlast beat is accepted.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/user_strm_src_arbiter_reg_slice.sv
`default_nettype none
// ============================================================================
// Module      : axisr_reg_slice
// Description : One AXI4SR register stage. Full throughput, one cycle of
//               latency; all master-side fields come straight from flops.
// Ports       : aclk, aresetn        clock / async active-low reset
//               s_t*                 sink side (tready = slot free or draining)
//               m_t*                 registered source side
// Revision    : 1.0 - initial release
// ============================================================================
module axisr_reg_slice #(
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic [ID_BITS-1:0]     s_tid,
    input  logic                   s_tlast,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic [ID_BITS-1:0]     m_tid,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready
);

    logic [DATA_BITS-1:0]   r_tdata;
    logic [DATA_BITS/8-1:0] r_tkeep;
    logic [ID_BITS-1:0]     r_tid;
    logic                   r_tlast;
    logic                   r_tvalid;

    // The slot can take a new beat when it is empty or is being drained now.
    assign s_tready = !r_tvalid || m_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tid    <= '0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (s_tready) begin
            r_tvalid <= s_tvalid;
            if (s_tvalid) begin
                r_tdata <= s_tdata;
                r_tkeep <= s_tkeep;
                r_tid   <= s_tid;
                r_tlast <= s_tlast;
            end
        end
    end

    assign m_tdata  = r_tdata;
    assign m_tkeep  = r_tkeep;
    assign m_tid    = r_tid;
    assign m_tlast  = r_tlast;
    assign m_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: rtl/user_strm_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : user_strm_src_arbiter
// Description : Packet-granular round-robin merge of N_IN AXI4SR source
//               streams into one registered host stream. Grants change only
//               at tlast boundaries; tid passes through unchanged.
// Ports       : aclk, aresetn        clock / async active-low reset
//               s_axis_t*            N_IN flattened input streams
//               m_axis_t*            merged output stream (register slice)
//               pkt_cnt              N_IN x 32-bit completed-packet counters,
//                                    present only with STRM_ARB_STATS_EN
// Config      : `define STRM_ARB_STATS_EN enables the packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
module user_strm_src_arbiter
    import user_strm_src_arbiter_pkg::*;
#(
    parameter int N_IN      = N_STRM_AXI,
    parameter int DATA_BITS = AXI_DATA_BITS,
    parameter int ID_BITS   = PID_BITS
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_IN*DATA_BITS-1:0]     s_axis_tdata,
    input  logic [N_IN*(DATA_BITS/8)-1:0] s_axis_tkeep,
    input  logic [N_IN*ID_BITS-1:0]       s_axis_tid,
    input  logic [N_IN-1:0]               s_axis_tlast,
    input  logic [N_IN-1:0]               s_axis_tvalid,
    output logic [N_IN-1:0]               s_axis_tready,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic [DATA_BITS/8-1:0]        m_axis_tkeep,
    output logic [ID_BITS-1:0]            m_axis_tid,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
`ifdef STRM_ARB_STATS_EN
    ,
    output logic [N_IN*ARB_CNT_BITS-1:0]  pkt_cnt
`endif
);

    localparam int IDX_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int KEEP_BITS = DATA_BITS / 8;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_rr_ptr_nxt;
    logic             r_run;      // low until the first edge after reset

    logic             w_gnt_valid;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_gnt_inc;
    logic [IDX_W:0]   w_cand;
    logic             w_sel_tvalid;
    logic             w_sel_tlast;
    logic             w_slice_ready;
    logic             w_accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ARB_IDLE;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_run     <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Grant / handshake outputs. In IDLE the winner is found combinationally
    // so its first beat can be taken in the decision cycle. The scan runs
    // from the far end back so the candidate closest to rr_ptr wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = '0;
        if (r_state == ARB_LOCK) begin
            w_gnt_valid = 1'b1;
            w_gnt_idx   = r_gnt_idx;
        end else if (r_run) begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
                if (w_cand >= (IDX_W + 1)'(N_IN)) begin
                    w_cand = w_cand - (IDX_W + 1)'(N_IN);
                end
                if (s_axis_tvalid[w_cand[IDX_W-1:0]]) begin
                    w_gnt_valid = 1'b1;
                    w_gnt_idx   = w_cand[IDX_W-1:0];
                end
            end
        end
    end

    assign w_sel_tvalid = w_gnt_valid && s_axis_tvalid[w_gnt_idx];
    assign w_sel_tlast  = s_axis_tlast[w_gnt_idx];
    assign w_accept     = w_sel_tvalid && w_slice_ready;
    assign w_gnt_inc    = (w_gnt_idx == IDX_W'(N_IN - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < N_IN; i++) begin
            s_axis_tready[i] = w_gnt_valid && (w_gnt_idx == IDX_W'(i)) && w_slice_ready;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_idx_nxt = r_gnt_idx;
        w_rr_ptr_nxt  = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept && w_sel_tlast) begin
                    w_rr_ptr_nxt = w_gnt_inc;
                end else if (w_accept) begin
                    w_state_nxt   = ARB_LOCK;
                    w_gnt_idx_nxt = w_gnt_idx;
                end
            end
            ARB_LOCK: begin
                // A tvalid gap on the owner never releases the grant.
                if (w_accept && w_sel_tlast) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = w_gnt_inc;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    axisr_reg_slice #(
        .DATA_BITS (DATA_BITS),
        .ID_BITS   (ID_BITS)
    ) u_out_slice (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_tdata  (s_axis_tdata[w_gnt_idx*DATA_BITS +: DATA_BITS]),
        .s_tkeep  (s_axis_tkeep[w_gnt_idx*KEEP_BITS +: KEEP_BITS]),
        .s_tid    (s_axis_tid[w_gnt_idx*ID_BITS +: ID_BITS]),
        .s_tlast  (w_sel_tlast),
        .s_tvalid (w_sel_tvalid),
        .s_tready (w_slice_ready),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tid    (m_axis_tid),
        .m_tlast  (m_axis_tlast),
        .m_tvalid (m_axis_tvalid),
        .m_tready (m_axis_tready)
    );

`ifdef STRM_ARB_STATS_EN
    logic [N_IN*ARB_CNT_BITS-1:0] r_pkt_cnt;

    // Only one input can complete a packet per cycle: the granted one.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_cnt <= '0;
        end else if (w_accept && w_sel_tlast) begin
            r_pkt_cnt[w_gnt_idx*ARB_CNT_BITS +: ARB_CNT_BITS] <=
                r_pkt_cnt[w_gnt_idx*ARB_CNT_BITS +: ARB_CNT_BITS] + ARB_CNT_BITS'(1);
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_user_strm_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_strm_src_arbiter
// Description : Scoreboard bench for user_strm_src_arbiter (N_IN=4, 32-bit
//               data). Drivers push expected beats in arbitration order; a
//               negedge monitor pops and compares every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_strm_src_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    logic            aclk;
    logic            aresetn;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N*IW-1:0] s_tid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [IW-1:0]   m_tid;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready;
`ifdef STRM_ARB_STATS_EN
    logic [N*32-1:0] pkt_cnt;
`endif

    logic [DW-1:0] td [N];
    logic [KW-1:0] tk [N];
    logic [IW-1:0] ti [N];
    logic          tl [N];
    logic          tv [N];
    logic          busy [N];
    logic          abort;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    beats_seen = 0;
    int    t_first = 0;
    int    t_last = 0;
    int    lock_viol = 0;
    logic  lock_watch = 1'b0;

    user_strm_src_arbiter #(
        .N_IN      (N),
        .DATA_BITS (DW),
        .ID_BITS   (IW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tid    (s_tid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tid    (m_tid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
`ifdef STRM_ARB_STATS_EN
        ,
        .pkt_cnt       (pkt_cnt)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = td[i];
            s_tkeep[i*KW +: KW] = tk[i];
            s_tid[i*IW +: IW]   = ti[i];
            s_tlast[i]          = tl[i];
            s_tvalid[i]         = tv[i];
        end
    end

    function automatic beat_t mk(int p, int n, int b, int nb, logic [IW-1:0] tid);
        beat_t r;
        r.data = {8'(p), 8'(n), 8'(b), 8'hA5};
        r.keep = (b == nb - 1) ? 4'h7 : 4'hF;
        r.id   = tid;
        r.last = (b == nb - 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got=0x%0h required=0x%0h", name, got, req);
        end
    endtask

    task automatic push_pkt(input int p, input int n, input int nb, input logic [IW-1:0] tid);
        for (int b = 0; b < nb; b++) exp_q.push_back(mk(p, n, b, nb, tid));
    endtask

    // Drive one packet on input p. Called just after a rising edge.
    task automatic send_pkt(input int p, input int n, input int nb, input logic [IW-1:0] tid,
                            input int gap_beat, input int gap_cyc);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            int  c;
            logic hs;
            if (b == gap_beat) begin
                tv[p] = 1'b0;
                repeat (gap_cyc) @(posedge aclk);
                #1;
            end
            bt = mk(p, n, b, nb, tid);
            td[p] = bt.data; tk[p] = bt.keep; ti[p] = bt.id; tl[p] = bt.last;
            tv[p] = 1'b1;
            c  = 0;
            hs = 1'b0;
            while (!hs) begin
                @(negedge aclk);
                hs = s_tready[p];
                @(posedge aclk);
                #1;
                if (abort) begin
                    tv[p] = 1'b0;
                    busy[p] = 1'b0;
                    return;
                end
                c++;
                if (!hs && c > 300) begin
                    checks++;
                    failures++;
                    $display("FAIL drv_timeout: input=%0d beat=%0d got=no_tready required=tready", p, b);
                    tv[p] = 1'b0;
                    busy[p] = 1'b0;
                    return;
                end
            end
            if (b == 0) busy[p] = 1'b1;
        end
        busy[p] = 1'b0;
        tv[p] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge aclk);
            c++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        beats_seen = 0;
    endtask

    // Scoreboard monitor
    always @(negedge aclk) begin
        beat_t got;
        beat_t e;
        cyc++;
        if (aresetn && lock_watch && busy[1] && s_tready[0]) lock_viol++;
        if (aresetn && m_tvalid && m_tready) begin
            got = {m_tdata, m_tkeep, m_tid, m_tlast};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got=0x%0h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb_beat: got=0x%0h required=0x%0h", got, e);
                end
            end
            beats_seen++;
            if (beats_seen == 1) t_first = cyc;
            t_last = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t snap;
        int    acc;
        int    stable_bad;
        int    c;
`ifdef STRM_ARB_STATS_EN
        logic [N*32-1:0] fv;
`endif
        abort    = 1'b0;
        aresetn  = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            td[i] = '0; tk[i] = '0; ti[i] = '0; tl[i] = 1'b0; tv[i] = 1'b0; busy[i] = 1'b0;
        end
        tv[0] = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata", 64'({m_tdata, m_tkeep, m_tid, m_tlast}), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
`ifdef STRM_ARB_STATS_EN
        check("rst_pkt_cnt", 64'(pkt_cnt == '0), 64'd1);
`endif
        tv[0] = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1) two inputs, continuous 4-beat packets, alternating order
        beats_seen = 0;
        push_pkt(0, 0, 4, 4'h1);
        push_pkt(1, 0, 4, 4'h2);
        push_pkt(0, 1, 4, 4'h1);
        push_pkt(1, 1, 4, 4'h2);
        fork
            begin send_pkt(0, 0, 4, 4'h1, -1, 0); send_pkt(0, 1, 4, 4'h1, -1, 0); end
            begin send_pkt(1, 0, 4, 4'h2, -1, 0); send_pkt(1, 1, 4, 4'h2, -1, 0); end
        join
        wait_drain("t1_drain");
        check("t1_contiguous", 64'(t_last - t_first), 64'd15);

        // 2) locked grant survives a tvalid gap on the owner
        do_reset();
        lock_viol  = 0;
        lock_watch = 1'b1;
        push_pkt(1, 0, 3, 4'h6);
        push_pkt(0, 0, 2, 4'h3);
        fork
            send_pkt(1, 0, 3, 4'h6, 1, 5);
            begin @(posedge aclk); #2; send_pkt(0, 0, 2, 4'h3, -1, 0); end
        join
        wait_drain("t2_drain");
        lock_watch = 1'b0;
        check("t2_lock_viol", 64'(lock_viol), 64'd0);

        // 3) output stall mid-packet
        do_reset();
        push_pkt(0, 2, 4, 4'h5);
        fork
            send_pkt(0, 2, 4, 4'h5, -1, 0);
            begin
                c = 0;
                while (beats_seen < 2 && c < 100) begin @(posedge aclk); #1; c++; end
                m_tready = 1'b0;
                acc = 0;
                stable_bad = 0;
                @(negedge aclk);
                snap = {m_tdata, m_tkeep, m_tid, m_tlast};
                if (s_tready[0] && tv[0]) acc++;
                for (int i = 1; i < 10; i++) begin
                    @(negedge aclk);
                    if ({m_tdata, m_tkeep, m_tid, m_tlast} !== snap || !m_tvalid) stable_bad++;
                    if (s_tready[0] && tv[0]) acc++;
                end
                check("t3_stable", 64'(stable_bad), 64'd0);
                check("t3_accept_le1", 64'(acc <= 1), 64'd1);
                @(posedge aclk);
                #1;
                m_tready = 1'b1;
            end
        join
        wait_drain("t3_drain");

        // 4) only in3 valid, single-beat packets every cycle
        do_reset();
        for (int n = 0; n < 6; n++) push_pkt(3, n, 1, 4'hC);
        for (int n = 0; n < 6; n++) send_pkt(3, n, 1, 4'hC, -1, 0);
        wait_drain("t4_drain");
        check("t4_throughput", 64'(t_last - t_first), 64'd5);

        // 5) reset on beat 2 of a 4-beat packet
        do_reset();
        push_pkt(1, 3, 2, 4'h9);   // only beats 0,1 reach the output
        exp_q[1].keep = 4'hF;
        exp_q[1].last = 1'b0;
        fork
            send_pkt(1, 3, 4, 4'h9, -1, 0);
            begin
                c = 0;
                while (beats_seen < 2 && c < 100) begin @(negedge aclk); #1; c++; end
                #1;
                aresetn = 1'b0;
                abort   = 1'b1;
                #1;
                check("t5_async_tvalid", 64'(m_tvalid), 64'd0);
                check("t5_rst_tready", 64'(s_tready), 64'd0);
`ifdef STRM_ARB_STATS_EN
                check("t5_pkt_cnt", 64'(pkt_cnt == '0), 64'd1);
`endif
                exp_q.delete();
                repeat (2) @(posedge aclk);
                #1;
                abort   = 1'b0;
                aresetn = 1'b1;
            end
        join
        push_pkt(0, 4, 1, 4'h1);
        push_pkt(1, 4, 1, 4'h2);
        fork
            send_pkt(1, 4, 1, 4'h2, -1, 0);
            send_pkt(0, 4, 1, 4'h1, -1, 0);
        join
        wait_drain("t5_drain");

`ifdef STRM_ARB_STATS_EN
        // 6) counter wrap
        do_reset();
        fv = '0;
        fv[31:0] = 32'hFFFF_FFFE;
        @(negedge aclk);
        #1;
        force dut.r_pkt_cnt = fv;
        #1;
        release dut.r_pkt_cnt;
        push_pkt(0, 5, 1, 4'h1);
        send_pkt(0, 5, 1, 4'h1, -1, 0);
        check("t6_cnt_ffffffff", 64'(pkt_cnt[31:0]), 64'hFFFF_FFFF);
        push_pkt(0, 6, 1, 4'h1);
        send_pkt(0, 6, 1, 4'h1, -1, 0);
        check("t6_cnt_wrap", 64'(pkt_cnt[31:0]), 64'h0);
        wait_drain("t6_drain");
`endif

        repeat (3) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
